// File: rtl/yuv_scan_ctrl_pkg.sv
// rtl/yuv_scan_ctrl_pkg.sv - converter mode codes and FSM states for the YUV scan controller
package yuv_pkg;

  localparam logic [1:0] MODE_Y    = 2'b10;
  localparam logic [1:0] MODE_U    = 2'b01;
  localparam logic [1:0] MODE_V    = 2'b00;
  localparam logic [1:0] MODE_IDLE = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_e;

  function automatic logic [1:0] plane_mode(input logic [1:0] plane);
    case (plane)
      2'd0:    plane_mode = MODE_Y;
      2'd1:    plane_mode = MODE_U;
      default: plane_mode = MODE_V;
    endcase
  endfunction

endpackage

// File: rtl/yuv_scan_ctrl_if.sv
// rtl/yuv_scan_ctrl_if.sv - control, image-SRAM read, converter and output-SRAM write signals
interface yuv_scan_ctrl_if #(
  parameter int IADDR_W = 10,
  parameter int OADDR_W = 12
);
  logic               start;
  logic               busy;
  logic               done;
  logic               img_ren;
  logic [IADDR_W-1:0] img_raddr;
  logic [1:0]         mode;
  logic               pad_en;
  logic               out_wen;
  logic [OADDR_W-1:0] out_waddr;

  modport master (
    input  start,
    output busy, done, img_ren, img_raddr, mode, pad_en, out_wen, out_waddr
  );

  modport slave (
    output start,
    input  busy, done, img_ren, img_raddr, mode, pad_en, out_wen, out_waddr
  );
endinterface

// File: rtl/yuv_scan_ctrl_pipe_delay.sv
// rtl/yuv_scan_ctrl_pipe_delay.sv - fixed-depth register chain, contents cleared on reset
module pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign q_o = d_i;
    end else begin : g_regs
      logic [WIDTH-1:0] stage_q [DEPTH];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= d_i;
          for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign q_o = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/yuv_scan_ctrl.sv
// rtl/yuv_scan_ctrl.sv - scans the padded image once per Y/U/V plane, feeding rgb2yuv and the output SRAM
module yuv_scan_ctrl
  import yuv_pkg::*;
#(
  parameter int IMG_W    = 32,
  parameter int IMG_H    = 32,
  parameter int PAD      = 1,
  parameter int RD_LAT   = 1,
  parameter int CONV_LAT = 4,
  parameter int IADDR_W  = 10,
  parameter int OADDR_W  = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  yuv_scan_ctrl_if.master bus
);

  localparam int PW   = IMG_W + 2 * PAD;
  localparam int PH   = IMG_H + 2 * PAD;
  localparam int NPIX = IMG_W * IMG_H;
  localparam int NTOT = 3 * PW * PH;
  localparam int CW   = $clog2(PW + 1);
  localparam int RW   = $clog2(PH + 1);

  state_e             state_q, state_d;
  logic [1:0]         plane_q, plane_d;
  logic [RW-1:0]      row_q, row_d;
  logic [CW-1:0]      col_q, col_d;
  logic [IADDR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [IADDR_W-1:0] raddr_q, raddr_d;
  logic [OADDR_W-1:0] wcnt_q, wcnt_d;

  logic               issue, row_pad, col_pad, pos_pad, rd_en, last_pos;
  logic               a_valid, a_pad, a_last;
  logic [1:0]         a_mode;
  logic               b_valid, b_last, done_w;
  logic [OADDR_W-1:0] b_waddr;

  generate
    if (PAD > 0) begin : g_pad
      assign row_pad = (row_q < RW'(PAD)) || (row_q >= RW'(PAD + IMG_H));
      assign col_pad = (col_q < CW'(PAD)) || (col_q >= CW'(PAD + IMG_W));
    end else begin : g_nopad
      assign row_pad = 1'b0;
      assign col_pad = 1'b0;
    end
  endgenerate

  assign issue    = (state_q == ISSUE);
  assign pos_pad  = row_pad | col_pad;
  assign rd_en    = issue & ~pos_pad;
  assign last_pos = (plane_q == 2'd2) && (row_q == RW'(PH - 1)) && (col_q == CW'(PW - 1));

  // Write address counts at the converter input stage, so its delay line only needs CONV_LAT.
  assign a_last = (wcnt_q == OADDR_W'(NTOT - 1));
  assign done_w = b_valid & b_last;

  always_comb begin
    state_d  = state_q;
    plane_d  = plane_q;
    row_d    = row_q;
    col_d    = col_q;
    rd_cnt_d = rd_cnt_q;
    raddr_d  = raddr_q;
    wcnt_d   = wcnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = ISSUE;
          plane_d  = '0;
          row_d    = '0;
          col_d    = '0;
          rd_cnt_d = '0;
          wcnt_d   = '0;
        end
      end
      ISSUE: begin
        if (col_q == CW'(PW - 1)) begin
          col_d = '0;
          if (row_q == RW'(PH - 1)) begin
            row_d   = '0;
            plane_d = plane_q + 2'd1;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
        if (last_pos) state_d = DRAIN;
      end
      DRAIN: begin
        if (done_w) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rd_en) begin
      raddr_d  = rd_cnt_q;
      rd_cnt_d = (rd_cnt_q == IADDR_W'(NPIX - 1)) ? '0 : rd_cnt_q + 1'b1;
    end
    if (a_valid) wcnt_d = wcnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      plane_q  <= '0;
      row_q    <= '0;
      col_q    <= '0;
      rd_cnt_q <= '0;
      raddr_q  <= '0;
      wcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      plane_q  <= plane_d;
      row_q    <= row_d;
      col_q    <= col_d;
      rd_cnt_q <= rd_cnt_d;
      raddr_q  <= raddr_d;
      wcnt_q   <= wcnt_d;
    end
  end

  pipe_delay #(.WIDTH(4), .DEPTH(RD_LAT)) u_rd_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   ({issue, pos_pad, plane_mode(plane_q)}),
    .q_o   ({a_valid, a_pad, a_mode})
  );

  pipe_delay #(.WIDTH(2 + OADDR_W), .DEPTH(CONV_LAT)) u_conv_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   ({a_valid, a_last, wcnt_q}),
    .q_o   ({b_valid, b_last, b_waddr})
  );

  // Pad positions hold the last real read address rather than the pending one.
  assign bus.img_ren   = rd_en;
  assign bus.img_raddr = rd_en ? rd_cnt_q : raddr_q;
  assign bus.mode      = a_valid ? a_mode : MODE_IDLE;
  assign bus.pad_en    = a_valid & a_pad;
  assign bus.out_wen   = b_valid;
  assign bus.out_waddr = b_waddr;
  assign bus.done      = done_w;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_yuv_scan_ctrl.sv
// tb/tb_yuv_scan_ctrl.sv - self-checking bench: vector table, frame reference model, converter model
module tb_yuv_scan_ctrl;
  import yuv_pkg::*;

  localparam int LAT = 5;
  localparam int NSNAP = 4096;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        wen;
    logic [11:0] waddr;
    logic        ren;
    logic [9:0]  raddr;
    logic [1:0]  mode;
    logic        pad;
  } snap_t;

  typedef struct {
    int         rel;
    bit         busy;
    bit         done;
    bit         wen;
    int         waddr;
    bit         ren;
    int         raddr;
    logic [1:0] mode;
    bit         pad;
  } vec_t;

  typedef struct {
    int dut;
    int cyc;
    int addr;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  yuv_scan_ctrl_if #(.IADDR_W(10), .OADDR_W(12)) b0 ();
  yuv_scan_ctrl_if #(.IADDR_W(10), .OADDR_W(12)) b1 ();

  yuv_scan_ctrl #(.IMG_W(4), .IMG_H(3), .PAD(1), .RD_LAT(1), .CONV_LAT(4),
                  .IADDR_W(10), .OADDR_W(12)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  yuv_scan_ctrl #(.IMG_W(2), .IMG_H(2), .PAD(0), .RD_LAT(1), .CONV_LAT(4),
                  .IADDR_W(10), .OADDR_W(12)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  snap_t       snap [0:1][0:NSNAP-1];
  ev_t         wr_q[$];
  ev_t         rd_q[$];
  ev_t         dn_q[$];
  logic [23:0] mem [0:15];
  logic [23:0] rdata;
  logic [7:0]  cst [0:3];

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Stand-in converter: distinct function per mode, RGB forced to zero on pad.
  function automatic logic [7:0] conv_fn(input logic [23:0] rgb, input logic [1:0] m, input logic pad);
    logic [7:0] r, g, b;
    if (m == MODE_IDLE) return 8'hEE;
    {r, g, b} = pad ? 24'h0 : rgb;
    case (m)
      MODE_Y:  return r + g + b + 8'h80;
      MODE_U:  return r - b;
      default: return g ^ b ^ {r[3:0], r[7:4]};
    endcase
  endfunction

  function automatic logic [7:0] ref_data(input int a);
    int plane, p, row, col;
    plane = a / 30;
    p     = a % 30;
    row   = p / 6;
    col   = p % 6;
    if (row < 1 || row >= 4 || col < 1 || col >= 5) return (plane == 0) ? 8'h80 : 8'h00;
    return conv_fn(mem[(row - 1) * 4 + (col - 1)], (plane == 0) ? MODE_Y : (plane == 1) ? MODE_U : MODE_V, 1'b0);
  endfunction

  always @(posedge clk) begin
    if (b0.img_ren) rdata <= mem[b0.img_raddr[3:0]];
    cst[0] <= conv_fn(rdata, b0.mode, b0.pad_en);
    cst[1] <= cst[0];
    cst[2] <= cst[1];
    cst[3] <= cst[2];
  end

  always @(negedge clk) begin
    if (cyc < NSNAP) begin
      snap[0][cyc] = {b0.busy, b0.done, b0.out_wen, b0.out_waddr, b0.img_ren, b0.img_raddr, b0.mode, b0.pad_en};
      snap[1][cyc] = {b1.busy, b1.done, b1.out_wen, b1.out_waddr, b1.img_ren, b1.img_raddr, b1.mode, b1.pad_en};
    end
    if (b0.out_wen) begin
      wr_q.push_back('{0, cyc, int'(b0.out_waddr)});
      chk(cst[3] == ref_data(int'(b0.out_waddr)), "wr_data", cst[3], ref_data(int'(b0.out_waddr)));
    end
    if (b0.img_ren) rd_q.push_back('{0, cyc, int'(b0.img_raddr)});
    if (b0.done)    dn_q.push_back('{0, cyc, int'(b0.out_waddr)});
    if (b1.out_wen) wr_q.push_back('{1, cyc, int'(b1.out_waddr)});
    if (b1.img_ren) rd_q.push_back('{1, cyc, int'(b1.img_raddr)});
    if (b1.done)    dn_q.push_back('{1, cyc, int'(b1.out_waddr)});
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_frame(input int d, input int s, input int w, input int h, input int pad, input string tag);
    int pw, ph, npos, n, cnt, bad, dcnt, dcyc, daddr, bbad, ri;
    ev_t exp_rd[$];
    ev_t act_rd[$];
    pw = w + 2 * pad;
    ph = h + 2 * pad;
    npos = pw * ph;
    n = 3 * npos;
    cnt = 0;
    bad = 0;
    foreach (wr_q[i]) begin
      if (wr_q[i].dut == d && wr_q[i].cyc >= s && wr_q[i].cyc <= s + n + LAT) begin
        if (wr_q[i].cyc != s + 1 + LAT + cnt || wr_q[i].addr != cnt) bad++;
        cnt++;
      end
    end
    chk(cnt == n, {tag, "_wr_count"}, cnt, n);
    chk(bad == 0, {tag, "_wr_seq"}, bad, 0);
    for (int pl = 0; pl < 3; pl++)
      for (int r = 0; r < ph; r++)
        for (int c = 0; c < pw; c++)
          if (r >= pad && r < pad + h && c >= pad && c < pad + w)
            exp_rd.push_back('{d, s + 1 + pl * npos + r * pw + c, (r - pad) * w + (c - pad)});
    foreach (rd_q[i])
      if (rd_q[i].dut == d && rd_q[i].cyc >= s && rd_q[i].cyc <= s + n) act_rd.push_back(rd_q[i]);
    chk(act_rd.size() == exp_rd.size(), {tag, "_rd_count"}, act_rd.size(), exp_rd.size());
    bad = 0;
    ri = (act_rd.size() < exp_rd.size()) ? act_rd.size() : exp_rd.size();
    for (int i = 0; i < ri; i++)
      if (act_rd[i].cyc != exp_rd[i].cyc || act_rd[i].addr != exp_rd[i].addr) bad++;
    chk(bad == 0, {tag, "_rd_seq"}, bad, 0);
    dcnt = 0;
    dcyc = -1;
    daddr = -1;
    foreach (dn_q[i]) begin
      if (dn_q[i].dut == d && dn_q[i].cyc >= s && dn_q[i].cyc <= s + n + LAT + 1) begin
        dcnt++;
        dcyc = dn_q[i].cyc - s;
        daddr = dn_q[i].addr;
      end
    end
    chk(dcnt == 1, {tag, "_done_count"}, dcnt, 1);
    chk(dcyc == n + LAT, {tag, "_done_cycle"}, dcyc, n + LAT);
    chk(daddr == n - 1, {tag, "_done_waddr"}, daddr, n - 1);
    bbad = 0;
    for (int c = s + 1; c <= s + n + LAT; c++) if (!snap[d][c].busy) bbad++;
    chk(bbad == 0, {tag, "_busy_hold"}, bbad, 0);
    chk(snap[d][s + n + LAT + 1].busy == 1'b0, {tag, "_busy_drop"}, snap[d][s + n + LAT + 1].busy, 0);
  endtask

  vec_t tbl [13];
  int   s1, s2, s3, s4, s5, s, r, bad;
  snap_t a, e;
  bit   ok;

  initial begin
    tbl[0]  = '{0,  0, 0, 0, 0,  0, 0, 2'b11, 0};
    tbl[1]  = '{1,  1, 0, 0, 0,  0, 0, 2'b11, 0};
    tbl[2]  = '{2,  1, 0, 0, 0,  0, 0, 2'b10, 1};
    tbl[3]  = '{6,  1, 0, 1, 0,  0, 0, 2'b10, 1};
    tbl[4]  = '{8,  1, 0, 1, 2,  1, 0, 2'b10, 1};
    tbl[5]  = '{9,  1, 0, 1, 3,  1, 1, 2'b10, 0};
    tbl[6]  = '{32, 1, 0, 1, 26, 0, 0, 2'b01, 1};
    tbl[7]  = '{39, 1, 0, 1, 33, 1, 1, 2'b01, 0};
    tbl[8]  = '{68, 1, 0, 1, 62, 1, 0, 2'b00, 1};
    tbl[9]  = '{91, 1, 0, 1, 85, 0, 0, 2'b00, 1};
    tbl[10] = '{92, 1, 0, 1, 86, 0, 0, 2'b11, 0};
    tbl[11] = '{95, 1, 1, 1, 89, 0, 0, 2'b11, 0};
    tbl[12] = '{96, 0, 0, 0, 0,  0, 0, 2'b11, 0};

    rst_n = 1'b0;
    b0.start = 1'b0;
    b1.start = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 24'($urandom);
    mem[0] = 24'hff0000;
    @(negedge clk);
    @(negedge clk);
    chk({b0.busy, b0.done, b0.img_ren, b0.img_raddr, b0.mode, b0.pad_en, b0.out_wen, b0.out_waddr}
        == {1'b0, 1'b0, 1'b0, 10'd0, 2'b11, 1'b0, 1'b0, 12'd0}, "reset_state",
        {b0.busy, b0.done, b0.img_ren, b0.img_raddr, b0.mode, b0.pad_en, b0.out_wen, b0.out_waddr},
        {1'b0, 1'b0, 1'b0, 10'd0, 2'b11, 1'b0, 1'b0, 12'd0});
    @(posedge clk);
    #1 rst_n = 1'b1;
    goto(cyc + 2);

    // Frame 1 with ignored starts at 10 and 95, frame 2 started at 96.
    s1 = cyc;
    b0.start = 1'b1;
    goto(s1 + 1);  b0.start = 1'b0;
    goto(s1 + 10); b0.start = 1'b1;
    goto(s1 + 11); b0.start = 1'b0;
    goto(s1 + 95); b0.start = 1'b1;
    goto(s1 + 96);
    s2 = cyc;
    goto(s2 + 1);  b0.start = 1'b0;
    goto(s2 + 100);

    for (int i = 0; i < 13; i++) begin
      a = snap[0][s1 + tbl[i].rel];
      e = {tbl[i].busy, tbl[i].done, tbl[i].wen, 12'(tbl[i].waddr), tbl[i].ren, 10'(tbl[i].raddr), tbl[i].mode, tbl[i].pad};
      ok = (a.busy == e.busy) && (a.done == e.done) && (a.wen == e.wen) && (a.ren == e.ren) &&
           (a.mode == e.mode) && (a.pad == e.pad) &&
           (!e.wen || a.waddr == e.waddr) && (!e.ren || a.raddr == e.raddr);
      chk(ok, $sformatf("vec%0d_rel%0d", i, tbl[i].rel), a, e);
    end
    check_frame(0, s1, 4, 3, 1, "f1");
    check_frame(0, s2, 4, 3, 1, "f2");

    // Reset pulse mid-frame, then a clean frame.
    s3 = cyc;
    b0.start = 1'b1;
    goto(s3 + 1);  b0.start = 1'b0;
    goto(s3 + 40); rst_n = 1'b0;
    goto(s3 + 41); rst_n = 1'b1;
    goto(s3 + 62);
    chk(snap[0][s3 + 39].busy && snap[0][s3 + 39].wen, "pre_rst_active", {snap[0][s3 + 39].busy, snap[0][s3 + 39].wen}, 2'b11);
    a = snap[0][s3 + 41];
    chk(!a.busy && !a.wen && !a.done && !a.ren && a.mode == 2'b11 && !a.pad, "post_rst_state", a, 29'h000_0006);
    bad = 0;
    for (int c = s3 + 41; c <= s3 + 60; c++) if (snap[0][c].wen || snap[0][c].busy) bad++;
    chk(bad == 0, "post_rst_quiet", bad, 0);
    s4 = cyc;
    b0.start = 1'b1;
    goto(s4 + 1); b0.start = 1'b0;
    goto(s4 + 100);
    check_frame(0, s4, 4, 3, 1, "after_rst");

    // Random images, random idle gaps and a stray start while busy.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 16; i++) mem[i] = 24'($urandom);
      goto(cyc + $urandom_range(0, 5));
      s = cyc;
      b0.start = 1'b1;
      goto(s + 1); b0.start = 1'b0;
      r = $urandom_range(2, 95);
      goto(s + r);     b0.start = 1'b1;
      goto(s + r + 1); b0.start = 1'b0;
      goto(s + 98);
      check_frame(0, s, 4, 3, 1, $sformatf("rnd%0d", k));
    end

    s5 = cyc;
    b1.start = 1'b1;
    goto(s5 + 1); b1.start = 1'b0;
    goto(s5 + 25);
    check_frame(1, s5, 2, 2, 0, "pad0");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
